// File: rtl/mac_8.sv
// Sequential 8-bit multiply-accumulate stage wrapped around the combinational mul_8.
// Accepts Len operand pairs on a valid/ready stream and presents their product sum downstream.

module mul_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] prod
);

  assign prod = 16'(a) * 16'(b);

endmodule

module mac_8 #(
  parameter int unsigned Len  = 4,
  parameter int unsigned AccW = 18
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [7:0]      a_i,
  input  logic [7:0]      b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [AccW-1:0] acc_o,
  output logic            ovf_o
);

  localparam int unsigned CntW = $clog2(Len + 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        a_q, b_q;
  logic              pv_q;
  logic [15:0]       prod;
  logic [AccW-1:0]   acc_q;
  logic              ovf_q;
  logic [CntW-1:0]   cnt_q;
  logic              accept;
  logic              last;
  logic [AccW:0]     sum;

  mul_8 u_mul (
    .a    (a_q),
    .b    (b_q),
    .prod (prod)
  );

  assign accept = valid_i && ready_o;
  assign last   = (cnt_q == CntW'(Len - 1));
  assign sum    = {1'b0, acc_q} + (AccW + 1)'(prod);

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

  // Handshake flags are decoded from state only; reset gates both low.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      ACCUM: begin
        ready_o = rst_ni;
        if (valid_i && last) state_d = DRAIN;
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        valid_o = rst_ni;
        if (ready_i) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ACCUM;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      pv_q    <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pv_q    <= accept;
      if (accept) begin
        a_q   <= a_i;
        b_q   <= b_i;
        cnt_q <= cnt_q + CntW'(1);
      end
      // No product is ever in flight while HOLD, so clear and add never collide.
      if (state_q == HOLD && ready_i) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
        cnt_q <= '0;
      end else if (pv_q) begin
        acc_q <= sum[AccW-1:0];
        ovf_q <= ovf_q | sum[AccW];
      end
    end
  end

endmodule

// File: tb/tb_mac_8.sv
// Self-checking bench for mac_8: four instances with different Len/AccW share one stimulus
// stream; a transaction-level model per instance predicts handshakes, sums and overflow.

module tb_mac_8;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_in;
  logic ready_in;
  logic [7:0] a_in, b_in;

  logic        rdy [4];
  logic        vld [4];
  logic        ovf [4];
  logic [17:0] acc0, acc2;
  logic [15:0] acc1, acc3;
  logic [31:0] acc_w [4];

  int checks = 0;
  int errors = 0;

  int lens  [4] = '{4, 2, 3, 1};
  int accws [4] = '{18, 16, 18, 16};

  // Model state per instance
  int m_cnt [4];
  int m_sum [4];
  bit m_ovf [4];
  bit m_full [4];
  int m_since [4];

  int unsigned res_acc [4][$];
  bit          res_ovf [4][$];

  always #5 clk = ~clk;

  mac_8 #(.Len(4), .AccW(18)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(rdy[0]), .a_i(a_in), .b_i(b_in),
    .valid_o(vld[0]), .ready_i(ready_in), .acc_o(acc0), .ovf_o(ovf[0]));
  mac_8 #(.Len(2), .AccW(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(rdy[1]), .a_i(a_in), .b_i(b_in),
    .valid_o(vld[1]), .ready_i(ready_in), .acc_o(acc1), .ovf_o(ovf[1]));
  mac_8 #(.Len(3), .AccW(18)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(rdy[2]), .a_i(a_in), .b_i(b_in),
    .valid_o(vld[2]), .ready_i(ready_in), .acc_o(acc2), .ovf_o(ovf[2]));
  mac_8 #(.Len(1), .AccW(16)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(rdy[3]), .a_i(a_in), .b_i(b_in),
    .valid_o(vld[3]), .ready_i(ready_in), .acc_o(acc3), .ovf_o(ovf[3]));

  assign acc_w[0] = 32'(acc0);
  assign acc_w[1] = 32'(acc1);
  assign acc_w[2] = 32'(acc2);
  assign acc_w[3] = 32'(acc3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Group of Len accepted pairs -> result visible two cycles after the last accept,
  // held until the downstream handshake; input stalled from the cycle after last accept.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        check($sformatf("d%0d_ready_rst", k), 32'(rdy[k]), 32'd0);
        check($sformatf("d%0d_valid_rst", k), 32'(vld[k]), 32'd0);
        m_cnt[k] = 0; m_sum[k] = 0; m_ovf[k] = 1'b0; m_full[k] = 1'b0; m_since[k] = 0;
      end else begin
        bit er, ev;
        int p, md;
        md = 1 << accws[k];
        if (m_full[k]) m_since[k]++;
        er = !m_full[k];
        ev = m_full[k] && (m_since[k] >= 2);
        check($sformatf("d%0d_ready", k), 32'(rdy[k]), 32'(er));
        check($sformatf("d%0d_valid", k), 32'(vld[k]), 32'(ev));
        if (ev) begin
          check($sformatf("d%0d_acc", k), acc_w[k], 32'(m_sum[k]));
          check($sformatf("d%0d_ovf", k), 32'(ovf[k]), 32'(m_ovf[k]));
        end
        if (er && valid_in) begin
          p = int'(a_in) * int'(b_in);
          if (m_sum[k] + p >= md) m_ovf[k] = 1'b1;
          m_sum[k] = (m_sum[k] + p) % md;
          m_cnt[k]++;
          if (m_cnt[k] == lens[k]) begin
            m_full[k]  = 1'b1;
            m_since[k] = 0;
          end
        end else if (ev && ready_in) begin
          res_acc[k].push_back(acc_w[k]);
          res_ovf[k].push_back(ovf[k]);
          m_cnt[k] = 0; m_sum[k] = 0; m_ovf[k] = 1'b0; m_full[k] = 1'b0; m_since[k] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      res_acc[k].delete();
      res_ovf[k].delete();
    end
  endtask

  // Hold a pair on the stream until instance k takes it.
  task automatic send(input int k, input logic [7:0] a, input logic [7:0] b);
    bit done = 1'b0;
    valid_in = 1'b1;
    a_in = a;
    b_in = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rdy[k] === 1'b1) done = 1'b1;
      tick();
    end
    if (!done) check($sformatf("d%0d_send_timeout", k), 32'd0, 32'd1);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_result(input int k, input int n);
    int i = 0;
    while (res_acc[k].size() < n && i < 100) begin
      tick();
      i++;
    end
    if (res_acc[k].size() < n) check($sformatf("d%0d_result_timeout", k), 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1; a_in = 8'd0; b_in = 8'd0;

    // Back-to-back mixed pairs
    do_reset();
    send(0, 8'd1, 8'd1); send(0, 8'd2, 8'd3); send(0, 8'd255, 8'd255); send(0, 8'd0, 8'd7);
    wait_result(0, 1);
    if (res_acc[0].size() >= 1) begin
      check("mixed_acc", res_acc[0][0], 32'd65032);
      check("mixed_ovf", 32'(res_ovf[0][0]), 32'd0);
    end

    // Maximum products without overflow at AccW=18
    do_reset();
    repeat (4) send(0, 8'd255, 8'd255);
    wait_result(0, 1);
    if (res_acc[0].size() >= 1) check("max_acc", res_acc[0][0], 32'd260100);

    // Overflow at AccW=16, then sticky flag cleared for next result
    do_reset();
    send(1, 8'd255, 8'd255); send(1, 8'd255, 8'd255);
    send(1, 8'd1, 8'd1); send(1, 8'd1, 8'd1);
    wait_result(1, 2);
    if (res_acc[1].size() >= 2) begin
      check("ovf_acc0", res_acc[1][0], 32'd64514);
      check("ovf_flag0", 32'(res_ovf[1][0]), 32'd1);
      check("ovf_acc1", res_acc[1][1], 32'd2);
      check("ovf_flag1", 32'(res_ovf[1][1]), 32'd0);
    end

    // Backpressure with new data offered while holding
    do_reset();
    ready_in = 1'b0;
    repeat (4) send(0, 8'd255, 8'd255);
    valid_in = 1'b1; a_in = 8'd1; b_in = 8'd1;
    repeat (7) tick();
    check("bp_no_result_yet", 32'(res_acc[0].size()), 32'd0);
    ready_in = 1'b1; a_in = 8'd1; b_in = 8'd2;
    repeat (6) tick();
    valid_in = 1'b0;
    wait_result(0, 2);
    if (res_acc[0].size() >= 2) begin
      check("bp_acc0", res_acc[0][0], 32'd260100);
      check("bp_acc1", res_acc[0][1], 32'd8);
    end

    // Gapped input at Len=3
    do_reset();
    send(2, 8'd10, 8'd10); idle(4);
    send(2, 8'd3, 8'd4); idle(1);
    send(2, 8'd0, 8'd255);
    wait_result(2, 1);
    if (res_acc[2].size() >= 1) check("gap_acc", res_acc[2][0], 32'd112);

    // Reset mid-operation drops the partial sum
    do_reset();
    send(0, 8'd5, 8'd5); send(0, 8'd5, 8'd5);
    rst_n = 1'b0; valid_in = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) send(0, 8'd2, 8'd2);
    wait_result(0, 1);
    check("rst_result_count", 32'(res_acc[0].size()), 32'd1);
    if (res_acc[0].size() >= 1) check("rst_acc", res_acc[0][0], 32'd16);

    // Random traffic with random backpressure and occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      a_in     = 8'($urandom);
      b_in     = 8'($urandom);
      ready_in = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
